// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for counter/timer primitives
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Prescaler register width; a divide-by-1 prescaler still needs one bit.
  function automatic int presc_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// rtl/clk_prescaler.sv - enable-driven step divider, one step every PRESCALE enabled cycles
module clk_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("clk_prescaler: PRESCALE must be >= 1");
  end

  logic [PW-1:0] presc;
  logic          at_last;

  assign at_last = (presc == LAST);
  // clr takes precedence so a clearing cycle never produces a step.
  assign step    = en & ~clr & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      presc <= at_last ? '0 : presc + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo-N up/down counter with load, prescaler, wrap/saturate
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_mod_counter: PRESCALE must be >= 1");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  // MODULUS-1 always fits in WIDTH bits, so all arithmetic stays in WIDTH.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;

  clk_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .step(step)
  );

  assign at_top       = (count == MAX_CNT);
  assign at_bot       = (count == '0);
  assign at_bound     = (up_dn == DIR_UP) ? at_top : at_bot;
  assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;
  assign tc           = at_bound;

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    sat_nxt   = sat;
    if (load) begin
      count_nxt = load_clamped;
      sat_nxt   = 1'b0;
    end else if (step) begin
      if (!at_bound) begin
        count_nxt = (up_dn == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
        sat_nxt   = 1'b0;
      end else if (SATURATE == CNT_SAT) begin
        sat_nxt   = 1'b1;
      end else begin
        count_nxt = (up_dn == DIR_UP) ? '0 : MAX_CNT;
        wrap_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] c0, c1, c2, c3, c4;
  logic       tc0, tc1, tc2, tc3, tc4;
  logic       w0, w1, w2, w3, w4;
  logic       s0, s1, s2, s3, s4;

  int n_tests;
  int n_fail;

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SATURATE(0)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(c0), .tc(tc0), .wrap(w0), .sat(s0));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(c1), .tc(tc1), .wrap(w1), .sat(s1));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(c2), .tc(tc2), .wrap(w2), .sat(s2));
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) u_d3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(c3), .tc(tc3), .wrap(w3), .sat(s3));
  updown_mod_counter #(.WIDTH(4), .MODULUS(8), .PRESCALE(1), .SATURATE(1)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(c4), .tc(tc4), .wrap(w4), .sat(s4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    tick();
    tick();
    check("rst_count", 32'(c0), 0);
    check("rst_wrap", 32'(w0), 0);
    check("rst_sat", 32'(s2), 0);
    check("rst_tc_up", 32'(tc0), 0);

    // 1: free-running up count over the full 2**WIDTH range
    rst = 1'b0;
    en  = 1'b1;
    #1;
    check("t1_no_step_before_edge", 32'(c0), 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("t1_count_%0d", i), 32'(c0), 32'(i % 16));
      check($sformatf("t1_wrap_%0d", i), 32'(w0), (i == 16) ? 1 : 0);
      check($sformatf("t1_tc_%0d", i), 32'(tc0), (i == 15) ? 1 : 0);
    end

    // 2: load 3 then count down through zero, wrapping to 9
    en = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    load = 1'b0;
    check("t2_load", 32'(c1), 3);
    up_dn = 1'b0; en = 1'b1;
    tick(); check("t2_c2", 32'(c1), 2); check("t2_w2", 32'(w1), 0);
    tick(); check("t2_c1", 32'(c1), 1);
    tick(); check("t2_c0", 32'(c1), 0); check("t2_tc0", 32'(tc1), 1); check("t2_w0", 32'(w1), 0);
    tick(); check("t2_c9", 32'(c1), 9); check("t2_w9", 32'(w1), 1); check("t2_tc9", 32'(tc1), 0);
    tick(); check("t2_c8", 32'(c1), 8); check("t2_w8", 32'(w1), 0);

    // 3: saturate at the top, then release by stepping down
    en = 1'b0; load = 1'b1; load_val = 4'd7; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); check("t3_c8", 32'(c2), 8); check("t3_s8", 32'(s2), 0);
    tick(); check("t3_c9", 32'(c2), 9); check("t3_s9", 32'(s2), 0); check("t3_tc9", 32'(tc2), 1);
    tick(); check("t3_hold1", 32'(c2), 9); check("t3_sat1", 32'(s2), 1); check("t3_nowrap", 32'(w2), 0);
    tick(); check("t3_hold2", 32'(c2), 9); check("t3_sat2", 32'(s2), 1);
    up_dn = 1'b0;
    #1;
    check("t3_tc_follows_dir", 32'(tc2), 0);
    tick(); check("t3_down8", 32'(c2), 8); check("t3_sat_clr", 32'(s2), 0);

    // 4: prescale by 3 with an en gap
    en = 1'b0; load = 1'b1; load_val = 4'd0; up_dn = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); check("t4_e1", 32'(c3), 0);
    en = 1'b0;
    tick(); tick(); check("t4_gap", 32'(c3), 0);
    en = 1'b1;
    tick(); check("t4_e2", 32'(c3), 0);
    tick(); check("t4_step1", 32'(c3), 1);
    tick(); tick(); check("t4_wait", 32'(c3), 1);
    tick(); check("t4_step2", 32'(c3), 2);

    // 5: load clamp, and load beating en with the prescaler mid-count
    en = 1'b0; load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0;
    check("t5_clamp_d3", 32'(c3), 9);
    check("t5_clamp_d2", 32'(c2), 9);
    check("t5_load_sat0", 32'(s2), 0);
    en = 1'b1;
    tick(); tick(); check("t5_presc2", 32'(c3), 9);
    load = 1'b1; load_val = 4'd4;
    tick(); check("t5_load_wins", 32'(c3), 4);
    load = 1'b0;
    tick(); check("t5_presc_clr_a", 32'(c3), 4);
    tick(); check("t5_presc_clr_b", 32'(c3), 4);
    tick(); check("t5_step", 32'(c3), 5);

    // 6: asynchronous reset mid-cycle at count 7 with sat set
    en = 1'b0; load = 1'b1; load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick(); check("t6_c7", 32'(c4), 7);
    tick(); check("t6_sat_set", 32'(s4), 1); check("t6_hold7", 32'(c4), 7);
    #2 rst = 1'b1;
    #1;
    check("t6_async_count", 32'(c4), 0);
    check("t6_async_sat", 32'(s4), 0);
    #2 rst = 1'b0;
    #1;
    check("t6_hold_after_release", 32'(c4), 0);
    tick(); check("t6_resume1", 32'(c4), 1);
    tick(); check("t6_resume2", 32'(c4), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
Parametrised modulo-N up/down counter, the next generation of the team's fixed 4-bit free-running up counter. Adds direction control, enable, synchronous load, a programmable prescaler, and wrap or saturate end behaviour. Status outputs are terminal-count, wrap and saturate. Intended as the generic count/timebase primitive for timers, address generators and divider chains.

Parameters:
WIDTH, 4, counter width in bits
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2**WIDTH
PRESCALE, 1, count steps once every PRESCALE enabled cycles; legal range >=1
SATURATE, 0, end behaviour: 0 = wrap, 1 = hold at bound

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high; clears all state immediately
en  input  1  count enable; advances the prescaler
up_dn  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
count  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational decode
wrap  output  1  one-cycle pulse, registered
sat  output  1  saturated flag, registered level

Behaviour:
- Reset (async, any time including mid-prescale):
  - count = 0, internal prescaler = 0, wrap = 0, sat = 0 immediately.
  - Outputs hold these values until the first rising clk edge after rst deasserts.
- Priority per edge: rst > load > en step. Inputs are sampled only at the rising edge.
- Load:
  - count <= min(load_val, MODULUS-1).
  - Prescaler cleared to 0, wrap <= 0, sat <= 0.
  - When load and en are both high, load wins and no step occurs that cycle.
- Prescaler:
  - Increments on each edge with en=1 and load=0; holds its value when en=0.
  - step = en && (presc == PRESCALE-1); on step the prescaler returns to 0.
  - PRESCALE=1 means every enabled edge is a step.
  - Changing up_dn does not affect the prescaler.
- Step up:
  - count < MODULUS-1: count+1.
  - count == MODULUS-1, SATURATE=0: count <= 0 and wrap <= 1.
  - count == MODULUS-1, SATURATE=1: count holds and sat <= 1.
- Step down:
  - count > 0: count-1.
  - count == 0, SATURATE=0: count <= MODULUS-1 and wrap <= 1.
  - count == 0, SATURATE=1: count holds and sat <= 1.
- wrap:
  - High for exactly the one cycle following the wrapping edge, coincident with the new count.
  - Cleared on every other edge.
- sat:
  - Set when a step is suppressed at a bound.
  - Cleared by load or by any step that changes count.
  - Remains 0 when SATURATE=0.
- tc = up_dn ? (count == MODULUS-1) : (count == 0). Combinational from count and up_dn, so it follows up_dn in the same cycle.
- Latency: with PRESCALE=1, count changes on the first rising edge after en is sampled high.
- Width rule: arithmetic is done in WIDTH bits. MODULUS == 2**WIDTH must still wrap correctly with no overflow bit.
- Parameter checks: MODULUS out of range or PRESCALE < 1 must fail elaboration.

Decomposition:
- Shared package counter_pkg:
  - Mode constants CNT_WRAP=0 and CNT_SAT=1.
  - Direction constants DIR_UP=1 and DIR_DN=0.
  - Helper function computing prescaler width as clog2(PRESCALE), minimum 1.
- One sub-module, clk_prescaler:
  - Parameter PRESCALE.
  - Inputs clk, rst, en, clr.
  - Output step.
  - Reused by other timer blocks.

Test Plan:
1. WIDTH=4, MODULUS=16, PRESCALE=1, up, en=1 after reset release -> count 0,1,...,15,0; tc=1 while count=15; wrap=1 only in the cycle count returns to 0.
2. MODULUS=10, load_val=3, then down with en=1 -> count 3,2,1,0,9; wrap pulses with count=9; tc=1 at count=0.
3. MODULUS=10, SATURATE=1, up from 7 -> 8,9,9,9 with sat=1 from the first held cycle; switch up_dn=0 -> count 8, sat=0.
4. PRESCALE=3, up, en=1 -> count steps every 3rd edge. Drop en for 2 cycles after the first enabled edge -> count and prescaler hold; the step occurs after 2 more enabled edges.
5. MODULUS=10, load_val=12 -> count=9. load=1 with en=1 and prescaler at 2 -> count=load value, no step, prescaler back to 0.
6. rst pulsed between clock edges at count=7 and sat=1 -> count=0 and sat=0 before the next edge; counting resumes 1,2,... after release.
